// File: rtl/snn_pkg.sv
// Shared defaults, FSM encoding and config address map for the spiking-layer sequencer.
package snn_pkg;

  localparam int DEF_N_IN    = 5;
  localparam int DEF_N_OUT   = 2;
  localparam int DEF_W       = 8;
  localparam int DEF_CNT_W   = 8;
  localparam int DEF_T_STEPS = 16;

  // First bias address; weights occupy 0..BIAS_BASE-1.
  localparam int BIAS_BASE = DEF_N_IN * DEF_N_OUT;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_PULSE = 3'd2,
    S_WAIT  = 3'd3,
    S_FIN   = 3'd4
  } state_e;

  function automatic int bias_base(input int n_in, input int n_out);
    return n_in * n_out;
  endfunction

endpackage

// File: rtl/snn_argmax.sv
// Combinational argmax over the packed spike counts; the lowest index wins a tie.
module snn_argmax #(
  parameter int N_OUT = 2,
  parameter int CNT_W = 8,
  parameter int IDX_W = 1
) (
  input  logic [CNT_W*N_OUT-1:0] counts_i,
  output logic [IDX_W-1:0]       winner_o,
  output logic                   no_spike_o
);

  logic [CNT_W-1:0] best;

  always_comb begin
    best     = counts_i[CNT_W-1:0];
    winner_o = '0;
    // Strict greater-than keeps the earlier index on equal counts.
    for (int i = 1; i < N_OUT; i++) begin
      if (counts_i[CNT_W*i +: CNT_W] > best) begin
        best     = counts_i[CNT_W*i +: CNT_W];
        winner_o = IDX_W'(i);
      end
    end
    no_spike_o = (best == '0);
  end

endmodule

// File: rtl/snn_layer_sequencer.sv
// Config register file, frame FSM and per-neuron spike counters in front of the Layer_1 spiking layer.
module snn_layer_sequencer
  import snn_pkg::*;
#(
  parameter int N_IN    = DEF_N_IN,
  parameter int N_OUT   = DEF_N_OUT,
  parameter int W       = DEF_W,
  parameter int T_STEPS = DEF_T_STEPS,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int ADDR_W  = 4,
  parameter int IDX_W   = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cfg_we,
  input  logic [ADDR_W-1:0]       cfg_addr,
  input  logic [W-1:0]            cfg_data,
  input  logic                    start,
  input  logic [N_IN-1:0]         pixel_in,
  output logic                    busy,
  output logic                    done,
  output logic [CNT_W*N_OUT-1:0]  spike_count,
  output logic [IDX_W-1:0]        winner,
  output logic                    no_spike,
  output logic [W*N_IN*N_OUT-1:0] L_weights,
  output logic [W*N_OUT-1:0]      L_bias,
  output logic [N_IN-1:0]         L_pixel,
  output logic                    L_reset,
  output logic                    L_pulse,
  input  logic [N_OUT-1:0]        spike_in
);

  localparam int N_W    = N_IN * N_OUT;
  localparam int B_BASE = bias_base(N_IN, N_OUT);
  localparam int N_CFG  = B_BASE + N_OUT;
  localparam int STEP_W = (T_STEPS > 1) ? $clog2(T_STEPS) : 1;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(T_STEPS - 1);

  state_e                 state_q, state_d;
  logic [STEP_W-1:0]      step_q, step_d;
  logic [N_IN-1:0]        pixel_q;
  logic [IDX_W-1:0]       winner_q, am_winner;
  logic                   no_spike_q, am_none;
  logic [CNT_W*N_OUT-1:0] count_d;
  logic                   start_acc, cfg_acc, last_wait;

  assign start_acc = (state_q == S_IDLE) && start;
  assign cfg_acc   = (state_q == S_IDLE) && cfg_we && (int'(cfg_addr) < N_CFG);
  assign last_wait = (state_q == S_WAIT) && (step_q == LAST_STEP);

  genvar gi;
  generate
    for (gi = 0; gi < N_W; gi++) begin : g_weight
      logic [W-1:0] w_q;
      always_ff @(posedge clk or posedge reset) begin
        if (reset)                                 w_q <= '0;
        else if (cfg_acc && int'(cfg_addr) == gi) w_q <= cfg_data;
      end
      assign L_weights[W*gi +: W] = w_q;
    end

    for (gi = 0; gi < N_OUT; gi++) begin : g_bias
      logic [W-1:0] b_q;
      always_ff @(posedge clk or posedge reset) begin
        if (reset)                                          b_q <= '0;
        else if (cfg_acc && int'(cfg_addr) == B_BASE + gi) b_q <= cfg_data;
      end
      assign L_bias[W*gi +: W] = b_q;
    end

    for (gi = 0; gi < N_OUT; gi++) begin : g_count
      logic [CNT_W-1:0] c_q, c_d;
      always_comb begin
        c_d = c_q;
        if (start_acc)
          c_d = '0;
        else if ((state_q == S_WAIT) && spike_in[gi] && (c_q != {CNT_W{1'b1}}))
          c_d = c_q + CNT_W'(1);
      end
      always_ff @(posedge clk or posedge reset) begin
        if (reset) c_q <= '0;
        else       c_q <= c_d;
      end
      assign count_d[CNT_W*gi +: CNT_W]     = c_d;
      assign spike_count[CNT_W*gi +: CNT_W] = c_q;
    end
  endgenerate

  // Fed with next-state counts so the result is already registered during the done cycle.
  snn_argmax #(
    .N_OUT (N_OUT),
    .CNT_W (CNT_W),
    .IDX_W (IDX_W)
  ) u_argmax (
    .counts_i   (count_d),
    .winner_o   (am_winner),
    .no_spike_o (am_none)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_CLR;
      S_CLR:   state_d = S_PULSE;
      S_PULSE: state_d = S_WAIT;
      S_WAIT:  state_d = (step_q == LAST_STEP) ? S_FIN : S_PULSE;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q != S_IDLE);
    done    = (state_q == S_FIN);
    L_reset = (state_q == S_IDLE) || (state_q == S_CLR);
    L_pulse = (state_q == S_PULSE);
  end

  always_comb begin
    step_d = step_q;
    if (start_acc)
      step_d = '0;
    else if ((state_q == S_WAIT) && !last_wait)
      step_d = step_q + STEP_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_q     <= '0;
      pixel_q    <= '0;
      winner_q   <= '0;
      no_spike_q <= 1'b1;
    end else begin
      step_q <= step_d;
      if (start_acc) begin
        pixel_q    <= pixel_in;
        winner_q   <= '0;
        no_spike_q <= 1'b1;
      end else if (last_wait) begin
        winner_q   <= am_winner;
        no_spike_q <= am_none;
      end
    end
  end

  assign L_pixel  = pixel_q;
  assign winner   = winner_q;
  assign no_spike = no_spike_q;

endmodule

// File: tb/tb_snn_layer_sequencer.sv
// Directed + randomized bench for snn_layer_sequencer against a frame-level reference model.
`timescale 1ns/1ps
module tb_snn_layer_sequencer;

  logic        clk = 1'b0;
  logic        reset, cfg_we, start;
  logic [3:0]  cfg_addr;
  logic [7:0]  cfg_data;
  logic [4:0]  pixel_in;
  logic [1:0]  spike_in;

  logic        busy, done, winner, no_spike, L_reset, L_pulse;
  logic [15:0] spike_count, L_bias;
  logic [79:0] L_weights;
  logic [4:0]  L_pixel;

  logic        s_busy, s_done, s_winner, s_no_spike, s_L_reset, s_L_pulse;
  logic [5:0]  s_spike_count;
  logic [15:0] s_L_bias;
  logic [79:0] s_L_weights;
  logic [4:0]  s_L_pixel;

  int checks = 0;
  int errors = 0;
  logic [7:0] m_w [10];
  logic [7:0] m_b [2];

  always #5 clk = ~clk;

  snn_layer_sequencer #(
    .N_IN(5), .N_OUT(2), .W(8), .T_STEPS(16), .CNT_W(8), .ADDR_W(4), .IDX_W(1)
  ) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .start(start), .pixel_in(pixel_in), .busy(busy), .done(done), .spike_count(spike_count),
    .winner(winner), .no_spike(no_spike), .L_weights(L_weights), .L_bias(L_bias),
    .L_pixel(L_pixel), .L_reset(L_reset), .L_pulse(L_pulse), .spike_in(spike_in)
  );

  snn_layer_sequencer #(
    .N_IN(5), .N_OUT(2), .W(8), .T_STEPS(16), .CNT_W(3), .ADDR_W(4), .IDX_W(1)
  ) dut_sat (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .start(start), .pixel_in(pixel_in), .busy(s_busy), .done(s_done), .spike_count(s_spike_count),
    .winner(s_winner), .no_spike(s_no_spike), .L_weights(s_L_weights), .L_bias(s_L_bias),
    .L_pixel(s_L_pixel), .L_reset(s_L_reset), .L_pulse(s_L_pulse), .spike_in(spike_in)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [79:0] exp_w();
    logic [79:0] v;
    for (int k = 0; k < 10; k++) v[8*k +: 8] = m_w[k];
    return v;
  endfunction

  function automatic logic [15:0] exp_b();
    return {m_b[1], m_b[0]};
  endfunction

  task automatic check_cfg(input string tag);
    check({tag, "_w"}, L_weights, exp_w());
    check({tag, "_b"}, L_bias, exp_b());
    check({tag, "_sw"}, s_L_weights, exp_w());
    check({tag, "_sb"}, s_L_bias, exp_b());
  endtask

  task automatic cfg_write(input logic [3:0] a, input logic [7:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    if (a < 4'd10)      m_w[a] = d;
    else if (a < 4'd12) m_b[int'(a) - 10] = d;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  // mode: 0 silent, 1 {every step, every 4th}, 2 random, 3 all ones, 4 tie 5/5
  task automatic run_frame(input logic [4:0] pix, input int mode, input bit disturb, input bit cfg_at_start);
    int cnt [2];
    int e8 [2];
    int e3 [2];
    int w8, w3, pulses, dones, t;
    logic [1:0]  s;
    logic [7:0]  rw;
    logic [15:0] ex8;
    logic [5:0]  ex3;
    cnt[0] = 0; cnt[1] = 0; pulses = 0; dones = 0;
    check("idle_busy", busy, 1'b0);
    start = 1'b1; pixel_in = pix;
    if (cfg_at_start) begin
      rw = 8'($urandom);
      cfg_we = 1'b1; cfg_addr = 4'd1; cfg_data = rw; m_w[1] = rw;
    end
    @(posedge clk); #1;
    start = 1'b0; cfg_we = 1'b0; pixel_in = 5'($urandom);
    check("clr_busy", busy, 1'b1);
    check("clr_lreset", L_reset, 1'b1);
    check("clr_s_lreset", s_L_reset, 1'b1);
    check("clr_lpulse", L_pulse, 1'b0);
    check("clr_pixel", L_pixel, pix);
    check("clr_s_pixel", s_L_pixel, pix);
    check("clr_count", spike_count, 16'd0);
    check_cfg("clr_cfg");
    for (int c = 2; c <= 34; c++) begin
      @(posedge clk); #1;
      start = 1'b0; cfg_we = 1'b0;
      spike_in = 2'($urandom);
      if ((c % 2) == 1) begin
        t = (c - 3) / 2;
        case (mode)
          0:       s = 2'b00;
          1:       s = {1'b1, (t % 4) == 3};
          2:       s = 2'($urandom);
          3:       s = 2'b11;
          default: s = {t >= 11, t < 5};
        endcase
        spike_in = s;
        for (int i = 0; i < 2; i++) if (s[i]) cnt[i]++;
      end
      if (disturb && c == 5) begin
        start = 1'b1; cfg_we = 1'b1; cfg_addr = 4'd0; cfg_data = 8'h55;
      end
      if (L_pulse) pulses++;
      if (done) dones++;
      check("pulse", L_pulse, (c % 2 == 0) && (c <= 32));
      check("s_pulse", s_L_pulse, (c % 2 == 0) && (c <= 32));
      check("busy", busy, 1'b1);
      check("s_busy", s_busy, 1'b1);
      check("done", done, c == 34);
      check("s_done", s_done, c == 34);
      if (c == 34) begin
        for (int i = 0; i < 2; i++) begin
          e8[i] = (cnt[i] > 255) ? 255 : cnt[i];
          e3[i] = (cnt[i] > 7) ? 7 : cnt[i];
        end
        w8 = 0; w3 = 0;
        for (int i = 1; i < 2; i++) begin
          if (e8[i] > e8[w8]) w8 = i;
          if (e3[i] > e3[w3]) w3 = i;
        end
        ex8 = {8'(e8[1]), 8'(e8[0])};
        ex3 = {3'(e3[1]), 3'(e3[0])};
        check("fin_count", spike_count, ex8);
        check("fin_winner", winner, w8);
        check("fin_nospike", no_spike, (e8[0] == 0) && (e8[1] == 0));
        check("fin_s_count", s_spike_count, ex3);
        check("fin_s_winner", s_winner, w3);
        check("fin_s_nospike", s_no_spike, (e3[0] == 0) && (e3[1] == 0));
      end
    end
    check("pulse_total", pulses, 16);
    check("done_total", dones, 1);
    for (int j = 0; j < 3; j++) begin
      @(posedge clk); #1;
      spike_in = 2'($urandom);
      check("post_busy", busy, 1'b0);
      check("post_done", done, 1'b0);
      check("post_lreset", L_reset, 1'b1);
      check("post_count", spike_count, ex8);
    end
    check_cfg("post_cfg");
  endtask

  initial begin
    reset = 1'b1; cfg_we = 1'b0; start = 1'b0;
    cfg_addr = '0; cfg_data = '0; pixel_in = '0; spike_in = '0;
    for (int k = 0; k < 10; k++) m_w[k] = 8'h00;
    m_b[0] = 8'h00; m_b[1] = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_lreset", L_reset, 1'b1);
    check("rst_lpulse", L_pulse, 1'b0);
    check("rst_count", spike_count, 16'd0);
    check("rst_winner", winner, 1'b0);
    check("rst_nospike", no_spike, 1'b1);
    check("rst_pixel", L_pixel, 5'd0);
    check_cfg("rst_cfg");
    reset = 1'b0;
    @(posedge clk); #1;

    cfg_write(4'd0, 8'h40); cfg_write(4'd1, 8'h20); cfg_write(4'd2, 8'hE0);
    cfg_write(4'd3, 8'h10); cfg_write(4'd4, 8'h00);
    for (int k = 5; k < 10; k++) cfg_write(4'(k), 8'h7F);
    cfg_write(4'd10, 8'h08);
    cfg_write(4'd11, 8'hF8);
    check_cfg("load");
    check("load_bias_lit", L_bias, 16'hF808);
    cfg_write(4'd15, 8'($urandom));
    cfg_write(4'd12, 8'($urandom));
    check_cfg("oob");

    run_frame(5'b10110, 0, 1'b0, 1'b0);
    run_frame(5'($urandom), 1, 1'b0, 1'b0);
    run_frame(5'($urandom), 4, 1'b0, 1'b0);
    run_frame(5'($urandom), 3, 1'b0, 1'b0);
    run_frame(5'($urandom), 2, 1'b1, 1'b0);
    cfg_write(4'd0, 8'h55);
    check_cfg("after_done");
    run_frame(5'($urandom), 2, 1'b0, 1'b1);
    for (int k = 0; k < 8; k++) cfg_write(4'($urandom), 8'($urandom));
    check_cfg("rand_cfg");
    for (int k = 0; k < 3; k++) run_frame(5'($urandom), 2, 1'b0, 1'b0);

    // Reset mid-frame during step 7's pulse, between clock edges.
    start = 1'b1; pixel_in = 5'b01101;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 2; c <= 16; c++) begin
      @(posedge clk); #1;
      spike_in = 2'b11;
    end
    #3 reset = 1'b1;
    #1;
    for (int k = 0; k < 10; k++) m_w[k] = 8'h00;
    m_b[0] = 8'h00; m_b[1] = 8'h00;
    check("arst_busy", busy, 1'b0);
    check("arst_done", done, 1'b0);
    check("arst_lreset", L_reset, 1'b1);
    check("arst_lpulse", L_pulse, 1'b0);
    check("arst_count", spike_count, 16'd0);
    check("arst_s_count", s_spike_count, 6'd0);
    check("arst_nospike", no_spike, 1'b1);
    check("arst_pixel", L_pixel, 5'd0);
    check_cfg("arst_cfg");
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("arst_nodone", done, 1'b0);
      check("arst_idle", busy, 1'b0);
    end
    run_frame(5'($urandom), 2, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/snn_layer_sequencer.md
Name: snn_layer_sequencer

Overview:
Control and configuration front-end for the Layer_1 spiking layer.
- Holds the layer's weight and bias registers, loaded word-by-word over a simple write port.
- On each start, latches one binary pixel frame, clears the layer, then issues T_STEPS pulse strobes.
- Counts output spikes per neuron and reports the counts plus the winning (argmax) neuron with a done strobe.

Parameters:
N_IN, 5, pixels per frame / inputs per neuron
N_OUT, 2, neurons in the layer
W, 8, signed weight/bias width (Q1.7)
T_STEPS, 16, pulse strobes per frame (>=1)
CNT_W, 8, per-neuron spike counter width
ADDR_W, 4, config address width (2^ADDR_W >= N_IN*N_OUT+N_OUT)
IDX_W, 1, winner index width (max(1,clog2(N_OUT)))

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state
cfg_we  in  1  config write strobe
cfg_addr  in  ADDR_W  0..N_IN*N_OUT-1 = weight[i][j] at i*N_IN+j; next N_OUT addresses = bias[i]
cfg_data  in  W  config word
start  in  1  begin one frame; sampled only in IDLE
pixel_in  in  N_IN  frame pixels, latched on accepted start
busy  out  1  high from accepted start until done cycle inclusive
done  out  1  one-cycle strobe, results valid
spike_count  out  CNT_W*N_OUT  neuron i at [CNT_W*i +: CNT_W], held until next accepted start
winner  out  IDX_W  argmax of spike_count, held with counts
no_spike  out  1  all counts zero, held with counts
L_weights  out  W*N_IN*N_OUT  to layer; weight[i][j] at [W*(N_IN*i+j) +: W]
L_bias  out  W*N_OUT  to layer; bias[i] at [W*i +: W]
L_pixel  out  N_IN  latched frame to layer
L_reset  out  1  layer reset, active-high
L_pulse  out  1  one-cycle layer timestep strobe
spike_in  in  N_OUT  layer spike outputs

Behaviour:
- Reset values: all config registers 0; L_pixel 0; L_reset 1; L_pulse 0; busy 0; done 0; counts 0; winner 0; no_spike 1; FSM in IDLE; step counter 0.
- FSM states: IDLE, CLR, PULSE, WAIT, FIN.
- IDLE: L_reset=1.
  - start=1 -> latch pixel_in into L_pixel, clear counts and step counter, go CLR.
- CLR: one cycle, L_reset=1, busy=1 -> PULSE.
- PULSE: L_reset=0, L_pulse=1 for exactly one cycle -> WAIT.
- WAIT: L_pulse=0.
  - spike_in sampled at end of cycle; count[i] += spike_in[i], saturating at 2^CNT_W-1.
  - If step==T_STEPS-1 -> FIN, else step+1 and -> PULSE.
- FIN: winner/no_spike registered from final counts; done=1 and busy=1 for this cycle -> IDLE.
- Latency: start accepted at cycle k -> CLR k+1 -> first pulse k+2 -> pulses every 2 cycles -> done at k+2*T_STEPS+2.
- Winner: largest count; ties go to the lowest index; all zero -> winner=0, no_spike=1.
- start outside IDLE is ignored, with no queuing. start held high re-triggers a new frame the cycle after FIN.
- Config writes:
  - Accepted only when busy=0 (including the IDLE cycle in which start is accepted).
  - Writes while busy are dropped, so weights are stable for a whole frame.
  - Out-of-range addresses are ignored.
  - A write in the same cycle as an accepted start takes effect and is visible from CLR onward.
- spike_in outside WAIT is ignored.
- Reset mid-frame: immediate return to reset values. No done is emitted, and the config is lost and must be reloaded.

Decomposition:
- Package snn_pkg: W, N_IN, N_OUT, CNT_W defaults; state enum encoding (IDLE=0, CLR=1, PULSE=2, WAIT=3, FIN=4); cfg address base constant BIAS_BASE=N_IN*N_OUT.
- One sub-module, snn_argmax: combinational N_OUT-way compare of the counts producing winner and no_spike with lowest-index tie-break. Its output is registered in the parent at FIN.
- Config register file and FSM stay in the top module.

Test Plan:
- Config load:
  - Stimulus: write weight[0][0..4]=0x40,0x20,0xE0,0x10,0x00; weight[1][*]=0x7F; bias[0]=0x08 (addr 10); bias[1]=0xF8 (addr 11).
  - Response: L_weights slices and L_bias=16'hF808 match exactly; addr 15 write leaves all registers unchanged.
- Frame timing:
  - Stimulus: T_STEPS=16, pixel_in=5'b10110, start pulse at cycle k; layer model drives spike_in=0.
  - Response: L_pixel=5'b10110; exactly 16 one-cycle L_pulse strobes at k+2,k+4,...,k+32; done at k+34; busy high k+1..k+34; no_spike=1, winner=0.
- Counting/argmax:
  - Stimulus: spike_in[1]=1 on every WAIT; spike_in[0]=1 on every 4th WAIT.
  - Response: counts {16,4}, winner=1, no_spike=0. Tie at {5,5} gives winner=0.
- Saturation:
  - Stimulus: CNT_W=3, spike_in=2'b11 every WAIT for 16 steps.
  - Response: both counts 7, with no wrap to 0.
- Lockout:
  - Stimulus: during a frame, cfg write addr 0 = 0x55 and a second start.
  - Response: weight[0][0] unchanged, no extra frame, done count 1. A write after done is accepted.
- Async reset:
  - Stimulus: assert reset between clock edges at step 7.
  - Response: immediately busy=0, L_reset=1, L_pulse=0, counts 0, weights 0, no done. A new start after release runs a full 16-step frame.
